io_watchdog_rst: RTL and testbench
==================================

Name: io_watchdog_rst

Overview:
- Konami-style I/O-mapper watchdog, fed by the board's async-preset D flip-flop stage: the CPU watchdog-kick strobe and the latched VBLANK level from that flip-flop are its inputs.
- Counts VBLANK rising edges; a CPU kick clears the count.
- On timeout, drives a fixed-length active-low CPU reset pulse, then applies a hold-off before re-arming.
- Runs on the global clk and qualifies every state change with the ck_ce clock enable.

Parameters:
- CNT_W, 4, width of the VBLANK edge counter; TIMEOUT must be ≤ 2^CNT_W.
- TIMEOUT, 8, VBLANK edges without a kick before the watchdog fires (≥1).
- RST_LEN, 16, cpu_rstn low duration in ce ticks (≥1).
- HOLDOFF, 4, VBLANK edges after reset release before re-arming (0 = re-arm immediately).

Ports:
- clk  in  1  global system clock; the only clock.
- Rn  in  1  asynchronous, active-low reset.
- ck_ce  in  1  clock enable; state advances only when high.
- vblank  in  1  active-high VBLANK level from the upstream flip-flop.
- kick  in  1  CPU watchdog write strobe; sampled on ck_ce.
- cpu_rstn  out  1  registered active-low reset to CPU.
- wd_cnt  out  CNT_W  current edge/hold-off count.
- fired  out  1  sticky flag: watchdog has fired at least once since Rn.

Behaviour:
- Rn low (async): state=HOLDOFF, wd_cnt=0, cpu_rstn=1, fired=0, vblank history reg=0, reset timer=0.
- Edge detect: vb_edge = vblank & ~vb_q; vb_q updates only on ck_ce. Only one edge per low→high transition.
- All transitions below occur only on a clk edge with ck_ce=1; with ck_ce=0 everything holds.
- ARMED:
  - kick=1 → wd_cnt=0. Kick wins over a simultaneous vb_edge.
  - else vb_edge with wd_cnt<TIMEOUT-1 → wd_cnt+1.
  - else vb_edge with wd_cnt==TIMEOUT-1 → FIRING; wd_cnt=0; cpu_rstn=0; fired=1; timer=RST_LEN-1.
- FIRING:
  - kick and vb_edge ignored (vb_q still tracks).
  - timer>0 → timer-1.
  - timer==0 → HOLDOFF; cpu_rstn=1; wd_cnt=0.
  - cpu_rstn stays low for exactly RST_LEN ce ticks.
- HOLDOFF:
  - kick ignored.
  - HOLDOFF==0 → ARMED on the next ce.
  - else vb_edge → wd_cnt+1; on reaching HOLDOFF → ARMED with wd_cnt=0.
- Latency: cpu_rstn falls one clk after the ce tick that samples the final edge. No combinational path from inputs to outputs.
- wd_cnt never wraps; it is bounded by TIMEOUT-1 or HOLDOFF.
- Rn asserted mid-FIRING: immediate async return to reset values, including cpu_rstn=1.
- Counting uses CNT_W-bit unsigned arithmetic; parameter violations are flagged by elaboration-time checks.

Optional Feature:
- Macro: WDOG_FREEZE_EN.
- Defined:
  - Adds input port freeze (1 bit).
  - While freeze=1 in ARMED, vb_edge does not increment wd_cnt, so the watchdog cannot fire; kick still clears.
  - FIRING and HOLDOFF ignore freeze.
  - Service/debug use.
- Undefined: no freeze port; behaviour as above.

Decomposition:
- Package wdog_pkg:
  - state typedef {ARMED, FIRING, HOLDOFF}, 2-bit encoding.
  - default constants WDOG_TIMEOUT_DEF=8, WDOG_RSTLEN_DEF=16, WDOG_HOLDOFF_DEF=4.
- Sub-module ce_edge_det: ce-qualified rising-edge detector with async active-low reset, clk/Rn port names; outputs vb_edge.

Test Plan (defaults; ck_ce high 1 clk in 4; VBLANK period 64 clk):
- Rn low mid-run → cpu_rstn=1, wd_cnt=0, fired=0 immediately; after release, 4 vblank edges → ARMED, wd_cnt=0.
- ARMED, no kicks → after 8th edge, cpu_rstn=0 one clk later, held exactly 16 ce ticks (64 clk); fired=1; then HOLDOFF.
- ARMED, kick every 5 edges → wd_cnt peaks at 5, never fires; cpu_rstn=1, fired=0.
- Kick on the same ce tick as the 8th edge, with wd_cnt=7 → wd_cnt=0, no fire.
- Kicks during FIRING and HOLDOFF → ignored: pulse length still 16 ticks, re-arm still after 4 edges.
- WDOG_FREEZE_EN, freeze=1 for 20 edges in ARMED → wd_cnt constant, no fire; freeze=0 → fires 8−wd_cnt edges later.

Source files
------------

// File: rtl/wdog_pkg.sv
// rtl/wdog_pkg.sv - shared state encoding and default timing constants for the I/O watchdog
package wdog_pkg;

  typedef enum logic [1:0] {
    WD_ARMED   = 2'd0,
    WD_FIRING  = 2'd1,
    WD_HOLDOFF = 2'd2
  } wd_state_t;

  localparam int WDOG_TIMEOUT_DEF = 8;
  localparam int WDOG_RSTLEN_DEF  = 16;
  localparam int WDOG_HOLDOFF_DEF = 4;

endpackage

// File: rtl/ce_edge_det.sv
// rtl/ce_edge_det.sv - clock-enable qualified rising-edge detector
module ce_edge_det (
  input  logic clk,
  input  logic Rn,
  input  logic ce,
  input  logic d,
  output logic vb_edge
);

  logic vb_q;

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      vb_q <= 1'b0;
    end else if (ce) begin
      vb_q <= d;
    end
  end

  // Only meaningful when ce is high; the consumer qualifies with ce as well.
  assign vb_edge = d & ~vb_q;

endmodule

// File: rtl/io_watchdog_rst.sv
// rtl/io_watchdog_rst.sv - VBLANK-counting watchdog driving a fixed-length CPU reset pulse
// Optional WDOG_FREEZE_EN adds a freeze input that stalls counting while armed.
module io_watchdog_rst
  import wdog_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = WDOG_TIMEOUT_DEF,
  parameter int RST_LEN = WDOG_RSTLEN_DEF,
  parameter int HOLDOFF = WDOG_HOLDOFF_DEF
) (
  input  logic             clk,
  input  logic             Rn,
  input  logic             ck_ce,
  input  logic             vblank,
  input  logic             kick,
`ifdef WDOG_FREEZE_EN
  input  logic             freeze,
`endif
  output logic             cpu_rstn,
  output logic [CNT_W-1:0] wd_cnt,
  output logic             fired
);

  localparam int TMR_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HO_LAST  = CNT_W'(HOLDOFF - 1);
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_LEN - 1);

  if (TIMEOUT < 1 || TIMEOUT > (1 << CNT_W)) begin : g_bad_timeout
    $error("io_watchdog_rst: TIMEOUT must be in 1..2**CNT_W");
  end
  if (RST_LEN < 1) begin : g_bad_rst_len
    $error("io_watchdog_rst: RST_LEN must be at least 1");
  end
  if (HOLDOFF < 0 || HOLDOFF > (1 << CNT_W)) begin : g_bad_holdoff
    $error("io_watchdog_rst: HOLDOFF must be in 0..2**CNT_W");
  end

  logic             frz;
  logic             vb_edge;
  wd_state_t        state;
  logic [TMR_W-1:0] timer;

`ifdef WDOG_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif

  ce_edge_det u_edge (
    .clk     (clk),
    .Rn      (Rn),
    .ce      (ck_ce),
    .d       (vblank),
    .vb_edge (vb_edge)
  );

  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      state    <= WD_HOLDOFF;
      wd_cnt   <= '0;
      cpu_rstn <= 1'b1;
      fired    <= 1'b0;
      timer    <= '0;
    end else if (ck_ce) begin
      case (state)
        WD_ARMED: begin
          if (kick) begin
            wd_cnt <= '0;
          end else if (vb_edge && !frz) begin
            if (wd_cnt == TO_LAST) begin
              state    <= WD_FIRING;
              wd_cnt   <= '0;
              cpu_rstn <= 1'b0;
              fired    <= 1'b1;
              timer    <= RST_LAST;
            end else begin
              wd_cnt <= wd_cnt + CNT_W'(1);
            end
          end
        end
        // Timer is loaded with RST_LEN-1 so the low phase spans exactly RST_LEN ticks.
        WD_FIRING: begin
          if (timer == '0) begin
            state    <= WD_HOLDOFF;
            cpu_rstn <= 1'b1;
            wd_cnt   <= '0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        WD_HOLDOFF: begin
          if (HOLDOFF == 0) begin
            state  <= WD_ARMED;
            wd_cnt <= '0;
          end else if (vb_edge) begin
            if (wd_cnt == HO_LAST) begin
              state  <= WD_ARMED;
              wd_cnt <= '0;
            end else begin
              wd_cnt <= wd_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state    <= WD_HOLDOFF;
          wd_cnt   <= '0;
          cpu_rstn <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_watchdog_rst.sv
// tb/tb_io_watchdog_rst.sv - scoreboard bench for io_watchdog_rst against a behavioural model
module tb_io_watchdog_rst;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int RST_LEN = 16;
  localparam int HOLDOFF = 4;
  localparam int M_ARM = 0, M_PULSE = 1, M_HOLD = 2;

  logic clk = 1'b0, Rn = 1'b0, ck_ce = 1'b0, vblank = 1'b0, kick = 1'b0, freeze = 1'b0;
  logic cpu_rstn, fired;
  logic [CNT_W-1:0] wd_cnt;

  io_watchdog_rst #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .RST_LEN(RST_LEN), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk      (clk),
    .Rn       (Rn),
    .ck_ce    (ck_ce),
    .vblank   (vblank),
    .kick     (kick),
`ifdef WDOG_FREEZE_EN
    .freeze   (freeze),
`endif
    .cpu_rstn (cpu_rstn),
    .wd_cnt   (wd_cnt),
    .fired    (fired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rstn;
    logic [CNT_W-1:0] cnt;
    logic             fired;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0, n_fail = 0;
  bit   started = 0;
  int   cyc = 0, vb_hi = 20, rst_left = 0, peak = 0, n_fires = 0;

  // Behavioural model: edges since last kick, ticks of reset still owed, hold-off edges seen.
  int m_mode, m_edges, m_ho, m_low_left;
  bit m_fired, m_vb;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_HOLD; m_edges = 0; m_ho = 0; m_low_left = 0; m_fired = 0; m_vb = 0;
  endtask

  function automatic exp_t m_expect();
    exp_t e;
    e.rstn  = (m_mode != M_PULSE);
    e.cnt   = (m_mode == M_ARM) ? CNT_W'(m_edges) : (m_mode == M_HOLD) ? CNT_W'(m_ho) : '0;
    e.fired = m_fired;
    return e;
  endfunction

  task automatic step_model(input bit k, input bit f);
    bit e;
    e = vblank && !m_vb;
    m_vb = vblank;
    case (m_mode)
      M_ARM: begin
        if (k) m_edges = 0;
        else if (e && !f) begin
          if (m_edges + 1 == TIMEOUT) begin
            m_mode = M_PULSE; m_low_left = RST_LEN; m_fired = 1; m_edges = 0; n_fires++;
          end else m_edges++;
        end
      end
      M_PULSE: begin
        m_low_left--;
        if (m_low_left == 0) begin m_mode = M_HOLD; m_ho = 0; end
      end
      default: begin
        if (HOLDOFF == 0) begin m_mode = M_ARM; m_edges = 0; end
        else if (e) begin
          m_ho++;
          if (m_ho == HOLDOFF) begin m_mode = M_ARM; m_edges = 0; m_ho = 0; end
        end
      end
    endcase
  endtask

  task automatic drive(input int kmode);
    bit edge_now;
    @(negedge clk);
    cyc++;
    if (cyc % 64 == 0) vb_hi = $urandom_range(4, 40);
    vblank   = (cyc % 64) < vb_hi;
    ck_ce    = (cyc % 4 == 0);
    edge_now = ck_ce && vblank && !m_vb;
    case (kmode)
      1:       kick = ($urandom_range(0, 39) == 0);
      2:       kick = ck_ce && m_mode == M_ARM && m_edges == 5;
      3:       kick = edge_now && m_mode == M_ARM && m_edges == TIMEOUT - 1;
      default: kick = 1'b0;
    endcase
    if (rst_left > 0) begin
      rst_left--;
      if (Rn) begin
        Rn = 1'b0;
        #1;
        chk("async_rst_cpu_rstn", cpu_rstn, 1);
        chk("async_rst_wd_cnt", wd_cnt, 0);
        chk("async_rst_fired", fired, 0);
      end
      model_reset();
    end else begin
      Rn = 1'b1;
      if (ck_ce) step_model(kick, freeze);
    end
    sb_q.push_back(m_expect());
    started = 1;
  endtask

  task automatic run(input int n, input int kmode);
    for (int i = 0; i < n; i++) drive(kmode);
  endtask

  task automatic run_until(input string name, input int mode, input int edges, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (m_mode == mode && m_edges == edges) break;
      drive(0);
    end
    if (i == budget) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        if (sb_q.size() == 0) chk("sb_underflow", 0, 1);
        else begin
          e = sb_q.pop_front();
          chk("cpu_rstn", cpu_rstn, e.rstn);
          chk("wd_cnt", wd_cnt, e.cnt);
          chk("fired", fired, e.fired);
        end
      end
    end
  end

  initial begin : pulse_mon
    int run_len = 0;
    forever begin
      @(posedge clk);
      #1;
      if (Rn && wd_cnt > peak) peak = wd_cnt;
      if (!Rn) run_len = 0;
      else if (!cpu_rstn) run_len++;
      else if (run_len > 0) begin
        chk("pulse_len_clk", run_len, RST_LEN * 4);
        run_len = 0;
      end
    end
  end

  initial begin
    model_reset();
    rst_left = 3;
    run(1500, 0);
    chk("free_run_fired", fired, 1);

    run_until("reach_firing", M_PULSE, 0, 2000);
    rst_left = 4;
    run(300, 0);

    rst_left = 4;
    run(8, 0);
    peak = 0;
    run(2000, 2);
    chk("kick5_peak", peak, 5);
    chk("kick5_fired", fired, 0);

    rst_left = 4;
    run(2500, 3);
    chk("kick_on_edge_fired", fired, 0);

    run(4000, 1);

`ifdef WDOG_FREEZE_EN
    rst_left = 4;
    run_until("frz_arm", M_ARM, 3, 3000);
    freeze = 1'b1;
    run(20 * 64, 0);
    chk("frz_hold_cnt", wd_cnt, 3);
    chk("frz_no_fire", cpu_rstn, 1);
    freeze = 1'b0;
    run(6 * 64, 0);
    chk("frz_release_fired", fired, 1);
`endif

    @(posedge clk);
    #2;
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
